// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with a 2-entry skid (main M, skid S), flush and interrupt injection.
// Latency 1 cycle accept->out_valid; in_ready is registered (low only while S holds a beat).
// Define PIPE_STAGE_PERF_EN to add saturating stall_cnt/flush_cnt ports.
module pipe_stage_reg #(
  parameter int                CTRL_W    = 32,
  parameter int                DATA_W    = 32,
  parameter int                PC_W      = 10,
  parameter logic [CTRL_W-1:0] INTR_CTRL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [PC_W-1:0]   in_alt,
  input  logic              in_taken,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [PC_W-1:0]   out_pc,
  output logic [PC_W-1:0]   out_alt,
  output logic              out_taken,
  input  logic              flush,
  input  logic              intr,
  output logic              intr_ack
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [15:0]       stall_cnt,
  output logic [15:0]       flush_cnt
`endif
);

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;
    logic [PC_W-1:0]   pc;
    logic [PC_W-1:0]   alt;
    logic              taken;
  } beat_t;

  beat_t m_q, s_q, beat_in;
  logic  m_vld, s_vld;
  logic  acc, cons, inj;

  // S valid implies M valid, so in_ready is simply "skid empty".
  assign in_ready = ~s_vld;
  assign acc      = in_valid & ~s_vld;
  assign cons     = m_vld & out_ready;
  assign inj      = intr & ~flush & acc;

  always_comb begin
    beat_in.ctrl  = in_ctrl;
    beat_in.data  = in_data;
    beat_in.pc    = in_pc;
    beat_in.alt   = in_alt;
    beat_in.taken = in_taken;
    if (intr) begin
      beat_in.ctrl  = INTR_CTRL;
      beat_in.pc    = in_pc - PC_W'(1);
      beat_in.alt   = '0;
      beat_in.taken = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_vld    <= 1'b0;
      s_vld    <= 1'b0;
      m_q      <= '0;
      s_q      <= '0;
      intr_ack <= 1'b0;
    end else begin
      intr_ack <= inj;
      if (flush) begin
        m_vld <= 1'b0;
        s_vld <= 1'b0;
      end else if (!m_vld || cons) begin
        if (s_vld) begin
          m_q   <= s_q;
          m_vld <= 1'b1;
          s_vld <= 1'b0;
        end else begin
          m_q   <= beat_in;
          m_vld <= acc;
        end
      end else if (acc) begin
        s_q   <= beat_in;
        s_vld <= 1'b1;
      end
    end
  end

  // Outputs are gated by M so an invalid slot never exposes stale fields.
  assign out_valid = m_vld;
  assign out_ctrl  = m_vld ? m_q.ctrl  : '0;
  assign out_data  = m_vld ? m_q.data  : '0;
  assign out_pc    = m_vld ? m_q.pc    : '0;
  assign out_alt   = m_vld ? m_q.alt   : '0;
  assign out_taken = m_vld & m_q.taken;

`ifdef PIPE_STAGE_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (m_vld && !out_ready && stall_cnt != 16'hFFFF)
        stall_cnt <= stall_cnt + 16'd1;
      if (flush && m_vld && flush_cnt != 16'hFFFF)
        flush_cnt <= flush_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Randomised + directed bench for pipe_stage_reg against a queue-based reference model.
module tb_pipe_stage_reg;
  localparam int CW = 32;
  localparam int DW = 32;
  localparam int PW = 10;
  localparam logic [CW-1:0] ICTRL = 32'hC0DE_0001;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, in_taken;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;
  logic [PW-1:0] in_pc, in_alt;
  logic          out_valid, out_ready, out_taken;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;
  logic [PW-1:0] out_pc, out_alt;
  logic          flush, intr, intr_ack;
`ifdef PIPE_STAGE_PERF_EN
  logic [15:0]   stall_cnt, flush_cnt;
`endif

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .PC_W(PW), .INTR_CTRL(ICTRL)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .in_pc(in_pc), .in_alt(in_alt), .in_taken(in_taken),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
    .out_pc(out_pc), .out_alt(out_alt), .out_taken(out_taken),
    .flush(flush), .intr(intr), .intr_ack(intr_ack)
`ifdef PIPE_STAGE_PERF_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the stage is a FIFO of depth 2 whose head is the output.
  typedef struct packed {
    logic [CW-1:0] ctrl;
    logic [DW-1:0] data;
    logic [PW-1:0] pc;
    logic [PW-1:0] alt;
    logic          taken;
  } beat_t;

  beat_t q[$];
  logic  ack_exp = 1'b0;
  int    stall_m = 0;
  int    flush_m = 0;

  function automatic beat_t incoming();
    beat_t b;
    b.ctrl  = intr ? ICTRL : in_ctrl;
    b.data  = in_data;
    b.pc    = intr ? PW'(in_pc - 1) : in_pc;
    b.alt   = intr ? '0 : in_alt;
    b.taken = intr ? 1'b0 : in_taken;
    return b;
  endfunction

  // Evaluated right after each rising edge using the inputs the DUT just sampled.
  task automatic model_step();
    logic acc, cons;
    if (rst) begin
      q.delete();
      ack_exp = 1'b0;
      stall_m = 0;
      flush_m = 0;
    end else begin
      acc  = in_valid && (q.size() < 2);
      cons = (q.size() > 0) && out_ready;
      ack_exp = intr && !flush && acc;
      if (q.size() > 0 && !out_ready && stall_m < 65535) stall_m++;
      if (flush && q.size() > 0 && flush_m < 65535) flush_m++;
      if (flush) q.delete();
      else begin
        if (cons) void'(q.pop_front());
        if (acc) q.push_back(incoming());
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #2;
  endtask

  always @(negedge clk) begin
    check("out_valid", 64'(out_valid), 64'(q.size() > 0));
    check("in_ready", 64'(in_ready), 64'(q.size() < 2));
    check("intr_ack", 64'(intr_ack), 64'(ack_exp));
    if (q.size() > 0) begin
      check("out_ctrl", 64'(out_ctrl), 64'(q[0].ctrl));
      check("out_data", 64'(out_data), 64'(q[0].data));
      check("out_pc", 64'(out_pc), 64'(q[0].pc));
      check("out_alt", 64'(out_alt), 64'(q[0].alt));
      check("out_taken", 64'(out_taken), 64'(q[0].taken));
    end else begin
      check("idle_ctrl", 64'(out_ctrl), 64'(0));
      check("idle_taken", 64'(out_taken), 64'(0));
    end
`ifdef PIPE_STAGE_PERF_EN
    check("stall_cnt", 64'(stall_cnt), 64'(stall_m));
    check("flush_cnt", 64'(flush_cnt), 64'(flush_m));
`endif
  end

  task automatic idle_inputs();
    in_valid = 0; in_ctrl = '0; in_data = '0; in_pc = '0; in_alt = '0; in_taken = 0;
    flush = 0; intr = 0;
  endtask

  task automatic send(input logic [CW-1:0] c);
    in_valid = 1; in_ctrl = c; in_data = {c[15:0], 16'h5A5A};
    in_pc = PW'(c * 3); in_alt = PW'(c + 7); in_taken = c[0];
  endtask

  initial begin
    rst = 1; out_ready = 0;
    idle_inputs();
    #1;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_out_ctrl", 64'(out_ctrl), 64'(0));
    check("rst_intr_ack", 64'(intr_ack), 64'(0));
    step(); step();
    rst = 0;
    step();

    // Streaming: one cycle latency, in_ready never drops.
    out_ready = 1;
    for (int k = 1; k <= 8; k++) begin
      send(CW'(k));
      step();
      check("stream_ctrl", 64'(out_ctrl), 64'(k));
      check("stream_rdy", 64'(in_ready), 64'(1));
    end
    idle_inputs();
    step();

    // Stall: A in M, B in S, C held off, then drained in order.
    out_ready = 0;
    send(32'hA); step();
    send(32'hB); step();
    check("stall_rdy", 64'(in_ready), 64'(0));
    check("stall_head", 64'(out_ctrl), 64'(32'hA));
    send(32'hC); step(); step();
    out_ready = 1; step();
    check("drain_b", 64'(out_ctrl), 64'(32'hB));
    step();
    check("drain_c", 64'(out_ctrl), 64'(32'hC));
    idle_inputs(); step();
    check("drain_empty", 64'(out_valid), 64'(0));

    // Flush with both entries full; the flush-cycle beat must vanish.
    out_ready = 0;
    send(32'h11); step();
    send(32'h22); step();
    send(32'h33); flush = 1; step();
    check("flush_valid", 64'(out_valid), 64'(0));
    check("flush_ctrl", 64'(out_ctrl), 64'(0));
    check("flush_rdy", 64'(in_ready), 64'(1));
    idle_inputs(); out_ready = 1; step();
    check("flush_gone", 64'(out_valid), 64'(0));

    // Interrupt injection with PC wrap.
    in_valid = 1; in_ctrl = 32'h5; in_data = 32'hABCD; in_pc = '0;
    in_alt = 10'h3FF; in_taken = 1; intr = 1;
    step();
    check("intr_ctrl", 64'(out_ctrl), 64'(ICTRL));
    check("intr_pc", 64'(out_pc), 64'(10'h3FF));
    check("intr_taken", 64'(out_taken), 64'(0));
    check("intr_alt", 64'(out_alt), 64'(0));
    check("intr_data", 64'(out_data), 64'(32'hABCD));
    check("intr_ack1", 64'(intr_ack), 64'(1));
    idle_inputs(); step();
    check("intr_ack0", 64'(intr_ack), 64'(0));

    // intr together with flush: flush wins, injection retried next cycle.
    in_valid = 1; in_ctrl = 32'h9; in_pc = 10'd20; intr = 1; flush = 1;
    step();
    check("if_valid", 64'(out_valid), 64'(0));
    check("if_ack", 64'(intr_ack), 64'(0));
    flush = 0; step();
    check("if_inj_ctrl", 64'(out_ctrl), 64'(ICTRL));
    check("if_inj_pc", 64'(out_pc), 64'(10'd19));
    check("if_inj_ack", 64'(intr_ack), 64'(1));
    idle_inputs(); step();

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_ctrl  = $urandom; in_data = $urandom;
      in_pc    = PW'($urandom); in_alt = PW'($urandom); in_taken = $urandom_range(0, 1) == 1;
      out_ready = ($urandom_range(0, 9) < 6);
      flush    = ($urandom_range(0, 15) == 0);
      intr     = ($urandom_range(0, 7) == 0);
      step();
    end
    idle_inputs();

    // Async reset mid-stall, asserted away from any edge.
    out_ready = 0;
    send(32'h77); step();
    send(32'h78); step();
    idle_inputs();
    rst = 1;
    q.delete(); ack_exp = 0; stall_m = 0; flush_m = 0;
    #1;
    check("arst_valid", 64'(out_valid), 64'(0));
    check("arst_ctrl", 64'(out_ctrl), 64'(0));
    check("arst_data", 64'(out_data), 64'(0));
    check("arst_rdy", 64'(in_ready), 64'(1));
    step();
    rst = 0;
    step();

`ifdef PIPE_STAGE_PERF_EN
    send(32'h1); step();
    idle_inputs();
    repeat (70000) step();
    check("stall_sat", 64'(stall_cnt), 64'(16'hFFFF));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
